// File: rtl/alg_pkg.sv
// alg_pkg: shared types and default constants for the R-peak sample scheduler.
//   sched_state_t : scheduler FSM states
//   evt_t         : {sample_num, rr} event record at default widths
package alg_pkg;
    localparam int DATA_WIDTH_DEF = 11;
    localparam int CTR_WIDTH_DEF  = 24;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WDOG_LIMIT_DEF = 1080;

    typedef enum logic [1:0] {
        IDLE,
        STAGE,
        CHECK
    } sched_state_t;

    typedef struct packed {
        logic [CTR_WIDTH_DEF-1:0]  sample_num;
        logic [DATA_WIDTH_DEF-1:0] rr;
    } evt_t;
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: synchronous FIFO of event records with simultaneous push/pop.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (dropped when full unless popping)
//   pop, dout  : read request and head record (zero while empty)
//   full, empty: occupancy flags
// DEPTH must be a power of two, at least 2.
module evt_fifo
    import alg_pkg::*;
#(
    parameter type T     = evt_t,
    parameter int  DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    cnt;
    logic           do_push, do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop) cnt <= do_push ? cnt + 1'b1 : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/alg_sample_sched.sv
// alg_sample_sched: per-sample scheduler for the R-peak detection chain.
//   i_clk, i_nrst                       : clock, asynchronous active-low reset
//   i_sample_valid/i_sample/o_sample_ready : sample input handshake
//   o_sample                            : latched sample, stable while stages run
//   o_stage_ce                          : one-hot stage enable, one stage per cycle
//   o_ctr                               : current sample index
//   i_r_peak_sample_num, i_rr_period, i_qrs_search_en : algorithm FSM status
//   o_evt_valid/i_evt_ready/o_evt_sample_num/o_evt_rr : event FIFO head
//   o_overflow                          : sticky event-dropped flag
//   o_wdog_alarm                        : no-peak watchdog, built only with SCHED_WDOG_EN
module alg_sample_sched
    import alg_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CTR_WIDTH  = CTR_WIDTH_DEF,
    parameter int STAGES     = 4,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_sample_valid,
    input  logic [DATA_WIDTH-1:0] i_sample,
    output logic                  o_sample_ready,
    output logic [DATA_WIDTH-1:0] o_sample,
    output logic [STAGES-1:0]     o_stage_ce,
    output logic [CTR_WIDTH-1:0]  o_ctr,
    input  logic [CTR_WIDTH-1:0]  i_r_peak_sample_num,
    input  logic [DATA_WIDTH-1:0] i_rr_period,
    input  logic                  i_qrs_search_en,
    output logic                  o_evt_valid,
    input  logic                  i_evt_ready,
    output logic [CTR_WIDTH-1:0]  o_evt_sample_num,
    output logic [DATA_WIDTH-1:0] o_evt_rr,
    output logic                  o_overflow,
    output logic                  o_wdog_alarm
);
    localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;

    typedef struct packed {
        logic [CTR_WIDTH-1:0]  sample_num;
        logic [DATA_WIDTH-1:0] rr;
    } evt_w_t;

    sched_state_t          state, state_next;
    logic [IW-1:0]         idx;
    logic                  started;
    logic                  accept, in_check, new_peak, push, pop, full, empty;
    logic [CTR_WIDTH-1:0]  last_peak;
    evt_w_t                head;

    // started keeps ready low for the first cycle after reset release.
    assign o_sample_ready = started && state == IDLE;
    assign o_stage_ce     = state == STAGE ? STAGES'(1) << idx : '0;
    assign accept         = i_sample_valid && o_sample_ready;
    assign in_check       = state == CHECK;
    assign new_peak       = i_r_peak_sample_num != last_peak && i_r_peak_sample_num != '0;
    assign push           = in_check && new_peak && i_qrs_search_en;
    assign pop            = o_evt_valid && i_evt_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? STAGE : IDLE;
            STAGE:   state_next = idx == IW'(STAGES-1) ? CHECK : STAGE;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state      <= IDLE;
            idx        <= '0;
            started    <= 1'b0;
            o_sample   <= '0;
            o_ctr      <= '0;
            last_peak  <= '0;
            o_overflow <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
            if (accept) begin
                o_sample <= i_sample;
                idx      <= '0;
            end else if (state == STAGE) begin
                idx <= idx + 1'b1;
            end
            if (in_check) begin
                o_ctr <= o_ctr + 1'b1;
                if (new_peak) last_peak <= i_r_peak_sample_num;
            end
            if (push && full && !pop) o_overflow <= 1'b1;
        end
    end

    evt_fifo #(
        .T     (evt_w_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_nrst),
        .push  (push),
        .din   ('{sample_num: i_r_peak_sample_num, rr: i_rr_period}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign o_evt_valid      = !empty;
    assign o_evt_sample_num = head.sample_num;
    assign o_evt_rr         = head.rr;

`ifdef SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_LIMIT + 1);

    logic [WW-1:0] wdog_cnt, wdog_next;

    // Saturates at the limit so a long silent stretch cannot wrap and clear the alarm.
    assign wdog_next = (new_peak || !i_qrs_search_en) ? '0 :
                       wdog_cnt == WW'(WDOG_LIMIT) ? wdog_cnt : wdog_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wdog_cnt     <= '0;
            o_wdog_alarm <= 1'b0;
        end else if (in_check) begin
            wdog_cnt     <= wdog_next;
            o_wdog_alarm <= wdog_next >= WW'(WDOG_LIMIT);
        end
    end
`else
    assign o_wdog_alarm = 1'b0;
`endif
endmodule

// File: tb/tb_alg_sample_sched.sv
// tb_alg_sample_sched: table-driven and randomized checks of alg_sample_sched against a queue-based model.
module tb_alg_sample_sched;
    localparam int DW = 11;
    localparam int CW = 24;
    localparam int ST = 4;
    localparam int FD = 4;
    localparam int WL = 10;
`ifdef SCHED_WDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_sample_valid = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic          o_sample_ready;
    logic [DW-1:0] o_sample;
    logic [ST-1:0] o_stage_ce;
    logic [CW-1:0] o_ctr;
    logic [CW-1:0] i_r_peak_sample_num = '0;
    logic [DW-1:0] i_rr_period = '0;
    logic          i_qrs_search_en = 1'b0;
    logic          o_evt_valid;
    logic          i_evt_ready = 1'b0;
    logic [CW-1:0] o_evt_sample_num;
    logic [DW-1:0] o_evt_rr;
    logic          o_overflow;
    logic          o_wdog_alarm;

    always #5 i_clk = ~i_clk;

    alg_sample_sched #(
        .DATA_WIDTH (DW),
        .CTR_WIDTH  (CW),
        .STAGES     (ST),
        .FIFO_DEPTH (FD),
        .WDOG_LIMIT (WL)
    ) dut (
        .i_clk               (i_clk),
        .i_nrst              (i_nrst),
        .i_sample_valid      (i_sample_valid),
        .i_sample            (i_sample),
        .o_sample_ready      (o_sample_ready),
        .o_sample            (o_sample),
        .o_stage_ce          (o_stage_ce),
        .o_ctr               (o_ctr),
        .i_r_peak_sample_num (i_r_peak_sample_num),
        .i_rr_period         (i_rr_period),
        .i_qrs_search_en     (i_qrs_search_en),
        .o_evt_valid         (o_evt_valid),
        .i_evt_ready         (i_evt_ready),
        .o_evt_sample_num    (o_evt_sample_num),
        .o_evt_rr            (o_evt_rr),
        .o_overflow          (o_overflow),
        .o_wdog_alarm        (o_wdog_alarm)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: ph = -1 idle, 0..ST-1 stage number, ST the check cycle.
    typedef struct {
        logic [CW-1:0] num;
        logic [DW-1:0] rr;
    } ev_s;

    int            ph;
    bit            started;
    logic [CW-1:0] m_ctr, m_last;
    logic [DW-1:0] m_sample;
    bit            m_ovf;
    bit            wd_alarm;
    ev_s           q[$];
`ifdef SCHED_WDOG_EN
    int            wd_cnt;
`endif

    task automatic model_reset();
        ph = -1;
        started = 0;
        m_ctr = '0;
        m_last = '0;
        m_sample = '0;
        m_ovf = 0;
        wd_alarm = 0;
        q.delete();
`ifdef SCHED_WDOG_EN
        wd_cnt = 0;
`endif
    endtask

    task automatic model_step();
        bit acc, pop, newp, push;
        acc = started && ph < 0 && i_sample_valid;
        pop = q.size() != 0 && i_evt_ready;
        push = 0;
        if (ph == ST) begin
            newp = i_r_peak_sample_num != m_last && i_r_peak_sample_num != 0;
            if (newp) m_last = i_r_peak_sample_num;
            push = newp && i_qrs_search_en;
            m_ctr = m_ctr + 1;
`ifdef SCHED_WDOG_EN
            wd_cnt = (newp || !i_qrs_search_en) ? 0 : (wd_cnt < WL ? wd_cnt + 1 : WL);
            wd_alarm = wd_cnt >= WL;
`endif
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < FD) q.push_back('{i_r_peak_sample_num, i_rr_period});
            else m_ovf = 1;
        end
        if (acc) begin
            ph = 0;
            m_sample = i_sample;
        end else if (ph == ST) ph = -1;
        else if (ph >= 0) ph++;
        started = 1;
    endtask

    task automatic compare_all();
        check("ready", o_sample_ready, started && ph < 0);
        check("stage_ce", o_stage_ce, (ph >= 0 && ph < ST) ? (1 << ph) : 0);
        check("sample", o_sample, m_sample);
        check("ctr", o_ctr, m_ctr);
        check("evt_valid", o_evt_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("evt_num", o_evt_sample_num, q[0].num);
            check("evt_rr", o_evt_rr, q[0].rr);
        end
        check("overflow", o_overflow, m_ovf);
        check("wdog", o_wdog_alarm, wd_alarm);
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (i_nrst) model_step();
        cyc++;
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_evt_num", o_evt_sample_num, 0);
        check("rst_evt_rr", o_evt_rr, 0);
        tick();
        #2;
        i_nrst = 1'b1;
        #1;
        compare_all();
        tick();
    endtask

    typedef struct {
        bit            rst_before;
        logic [DW-1:0] smp;
        logic [CW-1:0] pk;
        logic [DW-1:0] rr;
        bit            qrs;
        bit            er;
        logic [CW-1:0] e_ctr;
        bit            e_valid;
        logic [CW-1:0] e_head;
        logic [DW-1:0] e_head_rr;
        bit            e_ovf;
    } vec_t;

    vec_t tbl[15];
    int   drain_exp[4];

    // One full sample: handshake, stage walk, check cycle with i_evt_ready = v.er.
    task automatic do_txn(input vec_t v, output int acc_cyc);
        int w = 0;
        i_sample_valid = 1'b1;
        i_sample = v.smp;
        i_r_peak_sample_num = v.pk;
        i_rr_period = v.rr;
        i_qrs_search_en = v.qrs;
        i_evt_ready = 1'b0;
        while (!o_sample_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_before_accept", o_sample_ready, 1);
        tick();
        acc_cyc = cyc;
        i_sample_valid = 1'b0;
        i_sample = DW'($urandom);
        for (int k = 0; k < ST; k++) begin
            check("stage_onehot", o_stage_ce, 1 << k);
            check("latched_sample", o_sample, v.smp);
            tick();
        end
        i_evt_ready = v.er;
        tick();
        i_evt_ready = 1'b0;
    endtask

    initial begin
        int ac, prev_ac, n;
        vec_t v;
        model_reset();
        tbl[0]  = '{0, 5,  0,   0,   0, 0, 1, 0, 0,   0, 0};
        tbl[1]  = '{0, 6,  0,   0,   0, 0, 2, 0, 0,   0, 0};
        tbl[2]  = '{0, 7,  0,   0,   0, 0, 3, 0, 0,   0, 0};
        tbl[3]  = '{0, 8,  400, 0,   1, 0, 4, 1, 400, 0, 0};
        tbl[4]  = '{0, 9,  700, 300, 1, 0, 5, 1, 400, 0, 0};
        tbl[5]  = '{0, 10, 200, 150, 0, 0, 6, 1, 400, 0, 0};
        tbl[6]  = '{0, 11, 500, 77,  1, 0, 7, 1, 400, 0, 0};
        tbl[7]  = '{0, 12, 600, 100, 1, 0, 8, 1, 400, 0, 0};
        tbl[8]  = '{0, 13, 650, 50,  1, 0, 9, 1, 400, 0, 1};
        tbl[9]  = '{1, 20, 10,  1,   1, 0, 1, 1, 10,  1, 0};
        tbl[10] = '{0, 21, 20,  2,   1, 0, 2, 1, 10,  1, 0};
        tbl[11] = '{0, 22, 30,  3,   1, 0, 3, 1, 10,  1, 0};
        tbl[12] = '{0, 23, 40,  4,   1, 0, 4, 1, 10,  1, 0};
        tbl[13] = '{0, 24, 50,  5,   1, 1, 5, 1, 20,  2, 0};
        tbl[14] = '{0, 25, 50,  6,   1, 0, 6, 1, 20,  2, 0};
        drain_exp[0] = 400;
        drain_exp[1] = 700;
        drain_exp[2] = 500;
        drain_exp[3] = 600;
        prev_ac = 0;

        @(negedge i_clk);
        do_reset();

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            do_txn(tbl[i], ac);
            if (i == 1 || i == 2) check("ready_period", ac - prev_ac, ST + 2);
            prev_ac = ac;
            check("tbl_ctr", o_ctr, tbl[i].e_ctr);
            check("tbl_valid", o_evt_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check("tbl_head_num", o_evt_sample_num, tbl[i].e_head);
                check("tbl_head_rr", o_evt_rr, tbl[i].e_head_rr);
            end
            check("tbl_overflow", o_overflow, tbl[i].e_ovf);
            if (i == 8) begin
                i_evt_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    check("drain_num", o_evt_sample_num, drain_exp[k]);
                    tick();
                end
                i_evt_ready = 1'b0;
                check("drain_empty", o_evt_valid, 0);
                check("overflow_sticky", o_overflow, 1);
            end
        end

        // Reset while stage 2 is enabled.
        i_sample_valid = 1'b1;
        n = 0;
        while (!o_sample_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        check("ce_before_rst", o_stage_ce, 4'b0100);
        #2;
        do_reset();
        check("ready_second_cycle", o_sample_ready, 1);
        check("ctr_after_rst", o_ctr, 0);
        i_sample_valid = 1'b0;

        // Watchdog: ten checks without a peak, then a new peak.
        do_reset();
        for (int k = 1; k <= WL; k++) begin
            v = '{0, DW'(k), 0, 0, 1, 0, CW'(k), 0, 0, 0, 0};
            do_txn(v, ac);
            check("wdog_count", o_wdog_alarm, WD_ON && k >= WL);
        end
        v = '{0, 1, 123, 9, 1, 0, 0, 0, 0, 0, 0};
        do_txn(v, ac);
        check("wdog_clear", o_wdog_alarm, 0);
        check("wdog_peak_evt", o_evt_sample_num, 123);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            i_sample_valid = $urandom_range(0, 3) != 0;
            i_sample = DW'($urandom);
            i_evt_ready = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 3) == 0)
                i_r_peak_sample_num = $urandom_range(0, 5) == 0 ? '0 : CW'($urandom_range(1, 5000));
            i_rr_period = DW'($urandom);
            i_qrs_search_en = $urandom_range(0, 4) != 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
